// File: rtl/memory_arbiter_2port.sv
// Two-port read arbiter: instruction and data caches share one line-read memory port.
// Round-robin grant, one outstanding memory read at a time.
module memory_arbiter_2port #(
    parameter int ADDR_W = 6,
    parameter int LINE_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read_enable,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_read_ready,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_read_enable,
    input  logic [ADDR_W-1:0] d_address,
    output logic              d_read_ready,
    output logic [LINE_W-1:0] d_data,
    output logic              memory_read_enable,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_read_ready,
    input  logic [LINE_W-1:0] memory_data,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              complete, i_done, d_done, i_accept, d_accept, grant;

    assign complete = (state_q == S_WAIT) && memory_read_ready;
    assign i_done   = complete && !owner_q;
    assign d_done   = complete &&  owner_q;

    // The owner's flag stays set while it is served, so this also blocks owner
    // re-requests; only its completion cycle lets a new request through.
    assign i_accept = i_read_enable && (!i_pend_q || i_done);
    assign d_accept = d_read_enable && (!d_pend_q || d_done);

    // D wins only when I is idle or I was granted last.
    assign grant = d_pend_q && (!i_pend_q || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        i_pend_d     = i_accept ? 1'b1 : (i_done ? 1'b0 : i_pend_q);
        d_pend_d     = d_accept ? 1'b1 : (d_done ? 1'b0 : d_pend_q);
        i_addr_d     = i_accept ? i_address : i_addr_q;
        d_addr_d     = d_accept ? d_address : d_addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_pend_q || d_pend_q) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    mem_addr_d   = grant ? d_addr_q : i_addr_q;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (memory_read_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            i_pend_q     <= 1'b0;
            d_pend_q     <= 1'b0;
            i_addr_q     <= '0;
            d_addr_q     <= '0;
            mem_addr_q   <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            i_pend_q     <= i_pend_d;
            d_pend_q     <= d_pend_d;
            i_addr_q     <= i_addr_d;
            d_addr_q     <= d_addr_d;
            mem_addr_q   <= mem_addr_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign memory_read_enable = (state_q == S_ISSUE);
    assign memory_address     = mem_addr_q;
    assign busy               = (state_q != S_IDLE);
    assign owner              = owner_q;
    assign i_read_ready       = i_done;
    assign d_read_ready       = d_done;
    assign i_data             = memory_data;
    assign d_data             = memory_data;

endmodule

// File: tb/tb_memory_arbiter_2port.sv
// Directed bench for memory_arbiter_2port: inputs change on the falling edge,
// outputs are compared 1 ns later, well away from the rising edge.
module tb_memory_arbiter_2port;

    localparam int ADDR_W = 6;
    localparam int LINE_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              i_read_enable, d_read_enable;
    logic [ADDR_W-1:0] i_address, d_address;
    logic              i_read_ready, d_read_ready;
    logic [LINE_W-1:0] i_data, d_data;
    logic              memory_read_enable;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_read_ready;
    logic [LINE_W-1:0] memory_data;
    logic              busy, owner;

    int checks = 0;
    int errors = 0;

    memory_arbiter_2port #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clock(clock), .reset(reset),
        .i_read_enable(i_read_enable), .i_address(i_address),
        .i_read_ready(i_read_ready), .i_data(i_data),
        .d_read_enable(d_read_enable), .d_address(d_address),
        .d_read_ready(d_read_ready), .d_data(d_data),
        .memory_read_enable(memory_read_enable), .memory_address(memory_address),
        .memory_read_ready(memory_read_ready), .memory_data(memory_data),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and drop all one-cycle pulses.
    task automatic nxt();
        @(negedge clock);
        i_read_enable     = 1'b0;
        d_read_enable     = 1'b0;
        memory_read_ready = 1'b0;
    endtask

    task automatic do_reset();
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_read_enable = 1'b0; d_read_enable = 1'b0;
        i_address = '0; d_address = '0;
        memory_read_ready = 1'b0; memory_data = '0;
        nxt(); nxt();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mre", memory_read_enable, 0);
        chk("rst_addr", memory_address, 0);
        chk("rst_irdy", i_read_ready, 0);
        chk("rst_drdy", d_read_ready, 0);
        reset = 1'b0;

        // Single I request, memory answers 3 cycles after the read command.
        nxt(); i_read_enable = 1'b1; i_address = 6'h15;
        nxt(); #1; chk("t1_mre_idle", memory_read_enable, 0);
        nxt(); #1; chk("t1_mre", memory_read_enable, 1);
        chk("t1_addr", memory_address, 6'h15);
        chk("t1_owner", owner, 0);
        chk("t1_busy", busy, 1);
        nxt(); #1; chk("t1_mre_once", memory_read_enable, 0);
        nxt(); #1; chk("t1_irdy_early", i_read_ready, 0);
        nxt(); memory_read_ready = 1'b1; memory_data = 64'h0123456789ABCDEF; #1;
        chk("t1_irdy", i_read_ready, 1);
        chk("t1_idata", i_data, 64'h0123456789ABCDEF);
        chk("t1_drdy", d_read_ready, 0);
        chk("t1_addr_hold", memory_address, 6'h15);
        nxt(); #1; chk("t1_irdy_pulse", i_read_ready, 0);
        chk("t1_idle", busy, 0);

        // Simultaneous requests after reset: I first, then D.
        do_reset();
        nxt(); i_read_enable = 1'b1; i_address = 6'h01;
        d_read_enable = 1'b1; d_address = 6'h2A;
        nxt();
        nxt(); #1; chk("t2_own_i", owner, 0); chk("t2_addr_i", memory_address, 6'h01);
        nxt(); memory_read_ready = 1'b1; memory_data = 64'hAAAA; #1;
        chk("t2_irdy", i_read_ready, 1); chk("t2_drdy0", d_read_ready, 0);
        nxt();
        nxt(); #1; chk("t2_own_d", owner, 1); chk("t2_addr_d", memory_address, 6'h2A);
        chk("t2_mre_d", memory_read_enable, 1);
        nxt(); memory_read_ready = 1'b1; memory_data = 64'hBBBB; #1;
        chk("t2_drdy", d_read_ready, 1); chk("t2_irdy0", i_read_ready, 0);
        chk("t2_ddata", d_data, 64'hBBBB);

        // Both ports keep requesting; memory ready held high (ignored outside WAIT).
        do_reset();
        i_address = 6'h11; d_address = 6'h22;
        for (int t = 0; t <= 12; t++) begin
            @(negedge clock);
            i_read_enable = 1'b1; d_read_enable = 1'b1; memory_read_ready = 1'b1;
            #1;
            if (t > 0) begin
                chk("t3_irdy", i_read_ready, (t % 3 == 0) && (((t / 3) - 1) % 2 == 0));
                chk("t3_drdy", d_read_ready, (t % 3 == 0) && (((t / 3) - 1) % 2 == 1));
                if (t % 3 == 0)
                    chk("t3_addr", memory_address, (((t / 3) - 1) % 2 == 0) ? 6'h11 : 6'h22);
            end
        end

        // D requests during an I transfer; its repeat is ignored. Early ready pulses ignored.
        do_reset();
        nxt(); i_read_enable = 1'b1; i_address = 6'h30;
        nxt(); memory_read_ready = 1'b1; #1; chk("t4_idle_rdy", i_read_ready, 0);
        nxt(); memory_read_ready = 1'b1; #1; chk("t4_issue_rdy", i_read_ready, 0);
        chk("t4_mre", memory_read_enable, 1);
        nxt(); d_read_enable = 1'b1; d_address = 6'h07; #1;
        chk("t4_wait_hold", busy, 1);
        nxt(); d_read_enable = 1'b1; d_address = 6'h08; #1;
        chk("t4_wait_addr", memory_address, 6'h30);
        nxt(); memory_read_ready = 1'b1; #1; chk("t4_irdy", i_read_ready, 1);
        nxt();
        nxt(); #1; chk("t4_own_d", owner, 1); chk("t4_addr_d", memory_address, 6'h07);
        nxt(); memory_read_ready = 1'b1; #1; chk("t4_drdy", d_read_ready, 1);
        nxt(); #1; chk("t4_no_08", busy, 0);
        nxt(); #1; chk("t4_no_08b", busy, 0);

        // Reset during WAIT abandons the transfer; reset-cycle request discarded.
        do_reset();
        nxt(); i_read_enable = 1'b1; i_address = 6'h05;
        nxt(); nxt(); nxt();
        nxt(); reset = 1'b1; i_read_enable = 1'b1; i_address = 6'h09;
        nxt(); reset = 1'b0; memory_read_ready = 1'b1; #1;
        chk("t5_irdy", i_read_ready, 0); chk("t5_drdy", d_read_ready, 0);
        chk("t5_busy", busy, 0);
        nxt(); d_read_enable = 1'b1; d_address = 6'h3C; #1;
        chk("t5_discard", busy, 0);
        nxt();
        nxt(); #1; chk("t5_own_d", owner, 1); chk("t5_addr", memory_address, 6'h3C);
        nxt(); memory_read_ready = 1'b1; memory_data = 64'hFEED; #1;
        chk("t5_drdy_ok", d_read_ready, 1); chk("t5_ddata", d_data, 64'hFEED);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
